oled_frame_streamer: RTL and testbench

- Drives the 96x64 PmodOLEDrgb panel (SSD1331, RGB565) by scanning the frame in raster order.
- Presents pixel coordinates X/Y to the combinational sprite/colour renderers and samples their returned 16-bit colour.
- Serialises each colour over the 4-wire SPI, preceded by a column/row window command header.
- Panel power-up and initialisation are owned by a separate block. This block streams frames only, one per request.

---
 rtl/oled_pkg.sv | 43 ++++
 rtl/spi_shifter.sv | 66 ++++++
 rtl/oled_frame_streamer.sv | 103 ++++++++++
 tb/tb_oled_frame_streamer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// Shared definitions for the SSD1331 (PmodOLEDrgb) frame streamer and the colour renderers.
package oled_pkg;

   localparam int OLED_WIDTH   = 96;
   localparam int OLED_HEIGHT  = 64;
   localparam int HEADER_BYTES = 6;

   localparam logic [7:0] CMD_SET_COLUMN = 8'h15;
   localparam logic [7:0] CMD_SET_ROW    = 8'h75;

   // RGB565 palette shared with the sprite/colour renderers
   localparam logic [15:0] BLACK   = 16'h0000;
   localparam logic [15:0] WHITE   = 16'hFFFF;
   localparam logic [15:0] RED     = 16'hF800;
   localparam logic [15:0] GREEN   = 16'h07E0;
   localparam logic [15:0] BLUE    = 16'h001F;
   localparam logic [15:0] YELLOW  = 16'hFFE0;
   localparam logic [15:0] CYAN    = 16'h07FF;
   localparam logic [15:0] MAGENTA = 16'hF81F;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD_LOAD,
      ST_CMD_SHIFT,
      ST_PIX_LOAD,
      ST_PIX_SHIFT,
      ST_DONE
   } stream_state_t;

   // Window header: full-screen column range, then full-screen row range
   function automatic logic [7:0] header_byte(input logic [2:0] idx, input int width, input int height);
      logic [7:0] b;
      case (idx)
         3'd0:    b = CMD_SET_COLUMN;
         3'd2:    b = 8'(width - 1);
         3'd3:    b = CMD_SET_ROW;
         3'd5:    b = 8'(height - 1);
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/spi_shifter.sv
// MSB-first SPI serialiser for 8- or 16-bit words; sclk idles high, data changes while sclk is low.
module spi_shifter #(
   parameter int SCLK_HALF = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        load,
   input  logic [15:0] word,
   input  logic        wide16,
   output logic        sclk,
   output logic        sdin,
   output logic        done
);

   localparam int HW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

   logic [14:0]   shreg;
   logic [3:0]    bits_left;
   logic [HW-1:0] half_cnt;
   logic          active;
   logic          high_phase;
   logic          half_end;

   assign half_end = (half_cnt == HW'(SCLK_HALF - 1));
   // Asserted during the final cycle of the last bit so the FSM can move on at the same edge
   assign done     = active && high_phase && half_end && (bits_left == 4'd0);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         shreg      <= '0;
         bits_left  <= '0;
         half_cnt   <= '0;
         active     <= 1'b0;
         high_phase <= 1'b0;
         sclk       <= 1'b1;
         sdin       <= 1'b0;
      end else if (load) begin
         shreg      <= word[14:0];
         bits_left  <= wide16 ? 4'd15 : 4'd7;
         half_cnt   <= '0;
         active     <= 1'b1;
         high_phase <= 1'b0;
         sclk       <= 1'b0;
         sdin       <= word[15];
      end else if (active) begin
         if (!half_end) begin
            half_cnt <= half_cnt + 1'b1;
         end else begin
            half_cnt <= '0;
            if (!high_phase) begin
               high_phase <= 1'b1;
               sclk       <= 1'b1;
            end else if (bits_left == 4'd0) begin
               active <= 1'b0;
            end else begin
               high_phase <= 1'b0;
               sclk       <= 1'b0;
               bits_left  <= bits_left - 4'd1;
               sdin       <= shreg[14];
               shreg      <= {shreg[13:0], 1'b0};
            end
         end
      end
   end

endmodule

// File: rtl/oled_frame_streamer.sv
// Streams one full RGB565 frame to the SSD1331 per request: window header, then raster-ordered pixels.
module oled_frame_streamer
   import oled_pkg::*;
#(
   parameter int WIDTH     = OLED_WIDTH,
   parameter int HEIGHT    = OLED_HEIGHT,
   parameter int SCLK_HALF = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        frame_req,
   input  logic [15:0] pixel_data,
   output logic [6:0]  X,
   output logic [5:0]  Y,
   output logic        cs_n,
   output logic        sclk,
   output logic        sdin,
   output logic        dc,
   output logic        busy,
   output logic        frame_done
);

   stream_state_t state, state_next;

   logic [2:0]  byte_idx;
   logic        last_pix;
   logic        shift_done;
   logic        load;
   logic        wide16;
   logic [15:0] load_word;

   always_comb begin
      load      = (state == ST_CMD_LOAD) || (state == ST_PIX_LOAD);
      wide16    = (state == ST_PIX_LOAD);
      load_word = {header_byte(byte_idx, WIDTH, HEIGHT), 8'h00};
      if (state == ST_PIX_LOAD) load_word = pixel_data;
   end

   spi_shifter #(.SCLK_HALF(SCLK_HALF)) u_shifter (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (load),
      .word    (load_word),
      .wide16  (wide16),
      .sclk    (sclk),
      .sdin    (sdin),
      .done    (shift_done)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:      if (frame_req) state_next = ST_CMD_LOAD;
         ST_CMD_LOAD:  state_next = ST_CMD_SHIFT;
         ST_CMD_SHIFT: if (shift_done)
                          state_next = (byte_idx == 3'(HEADER_BYTES - 1)) ? ST_PIX_LOAD : ST_CMD_LOAD;
         ST_PIX_LOAD:  state_next = ST_PIX_SHIFT;
         ST_PIX_SHIFT: if (shift_done) state_next = last_pix ? ST_DONE : ST_PIX_LOAD;
         ST_DONE:      state_next = ST_IDLE;
         default:      state_next = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they describe
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         X          <= '0;
         Y          <= '0;
         byte_idx   <= '0;
         last_pix   <= 1'b0;
         cs_n       <= 1'b1;
         dc         <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         cs_n       <= (state_next == ST_IDLE) || (state_next == ST_DONE);
         busy       <= (state_next != ST_IDLE);
         frame_done <= (state_next == ST_DONE);
         if (state_next == ST_PIX_LOAD)       dc <= 1'b1;
         else if (state_next != ST_PIX_SHIFT) dc <= 1'b0;

         if (state == ST_IDLE)                       byte_idx <= '0;
         else if (state == ST_CMD_SHIFT && shift_done) byte_idx <= byte_idx + 3'd1;

         // Advance right after sampling so the renderer has the whole shift time to settle
         if (state == ST_PIX_LOAD) begin
            last_pix <= (X == 7'(WIDTH - 1)) && (Y == 6'(HEIGHT - 1));
            if (X == 7'(WIDTH - 1)) begin
               X <= '0;
               Y <= (Y == 6'(HEIGHT - 1)) ? 6'd0 : Y + 6'd1;
            end else begin
               X <= X + 7'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_oled_frame_streamer.sv
// Self-checking bench: decodes the SPI stream and compares it with a raster-order frame model.
module tb_oled_frame_streamer;

   localparam int W         = 12;
   localparam int H         = 6;
   localparam int SH        = 2;
   localparam int NPIX      = W * H;
   localparam int FRAME_CYC = 6 * (1 + 16 * SH) + NPIX * (1 + 32 * SH);

   logic        clk = 1'b0;
   logic        reset_n;
   logic        frame_req;
   logic [15:0] pixel_data;
   logic [6:0]  X;
   logic [5:0]  Y;
   logic        cs_n, sclk, sdin, dc, busy, frame_done;

   bit          mode;
   logic [15:0] tbl [NPIX];

   int checks   = 0;
   int failures = 0;

   // Monitor state
   int          cyc = 0;
   logic [16:0] cap_q[$];
   logic [15:0] acc;
   int          acc_n;
   logic        acc_dc;
   int          dc_bad, cs_gap, xy_trans, xy_bad;
   int          done_pulses, done_total, start_cyc, done_cyc;
   logic        busy_after, cs_at_done, row_wrap, frame_wrap;
   logic        prev_sclk, prev_busy, prev_done;
   int          px, py;

   oled_frame_streamer #(.WIDTH(W), .HEIGHT(H), .SCLK_HALF(SH)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .frame_req  (frame_req),
      .pixel_data (pixel_data),
      .X          (X),
      .Y          (Y),
      .cs_n       (cs_n),
      .sclk       (sclk),
      .sdin       (sdin),
      .dc         (dc),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // Behavioural renderer: a coordinate pattern or a random lookup table
   always_comb begin
      pixel_data = {X[4:0], Y, X[4:0]};
      if (mode && (int'(X) < W) && (int'(Y) < H)) pixel_data = tbl[int'(Y) * W + int'(X)];
   end

   // Passive monitor, sampling on the falling clk edge
   always @(negedge clk) begin
      cyc++;
      if (!reset_n) begin
         acc_n = 0;
         acc   = '0;
      end else begin
         if (!cs_n && sclk && !prev_sclk) begin
            if (acc_n == 0) acc_dc = dc;
            else if (dc !== acc_dc) dc_bad++;
            acc = {acc[14:0], sdin};
            acc_n++;
            if (acc_n == (acc_dc ? 16 : 8)) begin
               cap_q.push_back({acc_dc, acc});
               acc_n = 0;
               acc   = '0;
            end
         end
         if (busy && !prev_busy) start_cyc = cyc;
         if (busy && prev_busy && !frame_done && cs_n) cs_gap++;
         if (prev_done) busy_after = busy;
         if (frame_done) begin
            done_pulses++;
            done_total++;
            done_cyc   = cyc;
            cs_at_done = cs_n;
         end
         if (int'(X) != px || int'(Y) != py) begin
            xy_trans++;
            if (px == W - 1) begin
               if (int'(X) != 0 || int'(Y) != ((py == H - 1) ? 0 : py + 1)) xy_bad++;
            end else if (int'(X) != px + 1 || int'(Y) != py) begin
               xy_bad++;
            end
            if (px == W - 1 && py == 0 && X == 0 && Y == 1) row_wrap = 1'b1;
            if (px == W - 1 && py == H - 1 && X == 0 && Y == 0) frame_wrap = 1'b1;
         end
      end
      prev_sclk = sclk;
      prev_busy = busy;
      prev_done = frame_done;
      px        = int'(X);
      py        = int'(Y);
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus(input logic rst_n, input logic req);
      @(posedge clk);
      #2;
      reset_n   = rst_n;
      frame_req = req;
   endtask

   task automatic clear_stats();
      cap_q.delete();
      acc_n       = 0;
      dc_bad      = 0;
      cs_gap      = 0;
      xy_trans    = 0;
      xy_bad      = 0;
      done_pulses = 0;
      start_cyc   = -1;
      done_cyc    = -1;
      busy_after  = 1'b1;
      cs_at_done  = 1'b0;
      row_wrap    = 1'b0;
      frame_wrap  = 1'b0;
   endtask

   task automatic wait_frame(input string tag);
      int  start = done_total;
      bit  seen  = 0;
      for (int i = 0; i < FRAME_CYC + 200; i++) begin
         @(posedge clk);
         if (done_total != start) begin
            seen = 1;
            break;
         end
      end
      check_output({tag, "_done_seen"}, 32'(seen), 32'd1);
      @(posedge clk);
   endtask

   function automatic logic [15:0] model_pixel(input int x, input int y, input bit m);
      if (m) return tbl[y * W + x];
      return 16'(((x % 32) << 11) | ((y % 64) << 5) | (x % 32));
   endfunction

   task automatic verify_stream(input string tag, input bit m);
      logic [16:0] exp_q[$];
      logic [7:0]  hdr [6];
      logic [16:0] obs;
      int          bad = 0;
      hdr = '{8'h15, 8'h00, 8'(W - 1), 8'h75, 8'h00, 8'(H - 1)};
      for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, 8'h00, hdr[i]});
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) exp_q.push_back({1'b1, model_pixel(x, y, m)});
      check_output({tag, "_items"}, 32'(cap_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         obs = (i < cap_q.size()) ? cap_q[i] : 17'bx;
         if (obs !== exp_q[i]) bad++;
         if (i < 6) check_output($sformatf("%s_hdr%0d", tag, i), 32'(obs), 32'(exp_q[i]));
      end
      check_output({tag, "_px_0_0"}, (cap_q.size() > 6) ? 32'(cap_q[6]) : 32'hDEAD, 32'(exp_q[6]));
      check_output({tag, "_px_5_1"}, (cap_q.size() > 6 + W + 5) ? 32'(cap_q[6 + W + 5]) : 32'hDEAD,
                   32'(exp_q[6 + W + 5]));
      check_output({tag, "_bad_items"}, 32'(bad), 32'd0);
      check_output({tag, "_dc_glitch"}, 32'(dc_bad), 32'd0);
   endtask

   task automatic verify_timing(input string tag);
      check_output({tag, "_length"}, 32'(done_cyc - start_cyc), 32'(FRAME_CYC));
      check_output({tag, "_done_pulses"}, 32'(done_pulses), 32'd1);
      check_output({tag, "_cs_at_done"}, 32'(cs_at_done), 32'd1);
      check_output({tag, "_cs_gap"}, 32'(cs_gap), 32'd0);
      check_output({tag, "_busy_after"}, 32'(busy_after), 32'd0);
      check_output({tag, "_xy_trans"}, 32'(xy_trans), 32'(NPIX));
      check_output({tag, "_xy_order"}, 32'(xy_bad), 32'd0);
      check_output({tag, "_row_wrap"}, 32'(row_wrap), 32'd1);
      check_output({tag, "_frame_wrap"}, 32'(frame_wrap), 32'd1);
   endtask

   task automatic check_reset_values(input string tag);
      check_output({tag, "_cs_n"}, 32'(cs_n), 32'd1);
      check_output({tag, "_sclk"}, 32'(sclk), 32'd1);
      check_output({tag, "_sdin"}, 32'(sdin), 32'd0);
      check_output({tag, "_dc"}, 32'(dc), 32'd0);
      check_output({tag, "_busy"}, 32'(busy), 32'd0);
      check_output({tag, "_frame_done"}, 32'(frame_done), 32'd0);
      check_output({tag, "_X"}, 32'(X), 32'd0);
      check_output({tag, "_Y"}, 32'(Y), 32'd0);
   endtask

   initial begin
      int d1, dt, busy_seen;
      reset_n   = 1'b0;
      frame_req = 1'b0;
      mode      = 0;
      for (int i = 0; i < NPIX; i++) tbl[i] = 16'($urandom);
      clear_stats();
      done_total = 0;
      $display("[TB] oled_frame_streamer W=%0d H=%0d SCLK_HALF=%0d frame=%0d cycles", W, H, SH, FRAME_CYC);

      repeat (3) apply_stimulus(1'b0, 1'b0);
      check_reset_values("rst");
      apply_stimulus(1'b1, 1'b0);

      // Frame 1: coordinate pattern
      clear_stats();
      apply_stimulus(1'b1, 1'b1);
      apply_stimulus(1'b1, 1'b0);
      wait_frame("f1");
      verify_stream("f1", 0);
      verify_timing("f1");

      // Frame 2: random colours from a lookup table
      mode = 1;
      for (int i = 0; i < NPIX; i++) tbl[i] = 16'($urandom);
      clear_stats();
      apply_stimulus(1'b1, 1'b1);
      apply_stimulus(1'b1, 1'b0);
      wait_frame("f2");
      verify_stream("f2", 1);
      verify_timing("f2");

      // Back-to-back: frame_req held high through DONE
      for (int i = 0; i < NPIX; i++) tbl[i] = 16'($urandom);
      clear_stats();
      apply_stimulus(1'b1, 1'b1);
      wait_frame("b2b_a");
      verify_stream("b2b_a", 1);
      verify_timing("b2b_a");
      d1 = done_cyc;
      clear_stats();
      repeat (3) @(posedge clk);
      check_output("b2b_restart_cycle", 32'(start_cyc), 32'(d1 + 2));
      apply_stimulus(1'b1, 1'b0);
      repeat (200) @(posedge clk);
      apply_stimulus(1'b1, 1'b1);
      apply_stimulus(1'b1, 1'b0);
      wait_frame("b2b_b");
      verify_stream("b2b_b", 1);
      verify_timing("b2b_b");
      busy_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #2;
         if (busy) busy_seen++;
      end
      check_output("req_not_queued", 32'(busy_seen), 32'd0);

      // Abort mid-frame with reset, then a clean frame
      mode = 0;
      clear_stats();
      apply_stimulus(1'b1, 1'b1);
      apply_stimulus(1'b1, 1'b0);
      for (int i = 0; i < FRAME_CYC; i++) begin
         @(posedge clk);
         if (xy_trans >= 40) break;
      end
      check_output("abort_reached", 32'(xy_trans >= 40), 32'd1);
      dt = done_total;
      apply_stimulus(1'b0, 1'b1);
      apply_stimulus(1'b0, 1'b1);
      check_reset_values("abort");
      apply_stimulus(1'b0, 1'b1);
      apply_stimulus(1'b1, 1'b0);
      repeat (5) @(posedge clk);
      check_output("abort_no_done", 32'(done_total), 32'(dt));
      check_output("abort_idle", 32'(busy), 32'd0);
      clear_stats();
      apply_stimulus(1'b1, 1'b1);
      apply_stimulus(1'b1, 1'b0);
      wait_frame("f3");
      verify_stream("f3", 0);
      verify_timing("f3");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
